// File: rtl/mem_access_if.sv
// -----------------------------------------------------------------------------
// mem_access_if
// Data-cache request/response bundle between the MEM stage and the D-cache.
//   dmem_read        : load request (held until dmem_resp)
//   dmem_write       : store request (held until dmem_resp)
//   dmem_addr        : word-aligned request address
//   dmem_wdata       : store data, already replicated into lane position
//   dmem_byte_enable : store byte lanes
//   dmem_rdata       : word-aligned read data from the cache
//   dmem_resp        : one-cycle response per request
// master = pipeline side, slave = cache side.
// -----------------------------------------------------------------------------
interface mem_access_if #(
  parameter int XLEN = 32
);
  logic            dmem_read;
  logic            dmem_write;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_byte_enable;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_resp;

  modport master (
    output dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_enable,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_enable,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// MEM pipeline stage plus the MEM/WB pipeline register.
// Issues data-cache requests for loads/stores coming out of EX/MEM, aligns and
// extends load data, lane-shifts store data and byte enables, and raises the
// data-side stall while a request is outstanding. A response that arrives while
// the front end is stalled is parked in a hold register so it is not lost.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   exmem_*              : EX/MEM pipeline fields
//   istall_n             : instruction side not stalled
//   dmem (master)        : data-cache request/response bundle
//   dside_stall_n        : data side not stalled
//   memwb_*              : MEM/WB pipeline register outputs (incl. monitor fields)
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              exmem_valid,
  input  logic [XLEN-1:0]   exmem_alu_result,
  input  logic [XLEN-1:0]   exmem_rs2_data,
  input  logic [2:0]        exmem_funct3,
  input  logic              exmem_mem_read,
  input  logic              exmem_mem_write,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd_addr,

  input  logic              istall_n,

  mem_access_if.master      dmem,

  output logic              dside_stall_n,

  output logic              memwb_valid,
  output logic              memwb_reg_write,
  output logic              memwb_is_load,
  output logic [4:0]        memwb_rd_addr,
  output logic [XLEN-1:0]   memwb_alu_result,
  output logic [XLEN-1:0]   memwb_read_data,
  output logic [XLEN-1:0]   memwb_mem_addr,
  output logic [3:0]        memwb_mem_rmask,
  output logic [3:0]        memwb_mem_wmask,
  output logic [XLEN-1:0]   memwb_mem_wdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Byte mask for a B/H/W access selected by funct3[1:0]. Halves use addr[1]
  // only; words ignore the offset entirely.
  function automatic logic [3:0] access_mask(input logic [1:0] size,
                                             input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << {off[1], 1'b0};
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Extract and sign/zero-extend the addressed byte or half of the cache word.
  function automatic logic [XLEN-1:0] load_align(input logic [2:0]      f3,
                                                 input logic [1:0]      off,
                                                 input logic [XLEN-1:0] word);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replicate store data across all lanes; the byte enables pick the lane.
  function automatic logic [XLEN-1:0] store_shift(input logic [1:0]      size,
                                                  input logic [XLEN-1:0] data);
    logic [XLEN-1:0] r;
    case (size)
      2'b00:   r = {4{data[7:0]}};
      2'b01:   r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] hold_q, hold_d;

  logic            memwb_valid_q,      memwb_valid_d;
  logic            memwb_reg_write_q,  memwb_reg_write_d;
  logic            memwb_is_load_q,    memwb_is_load_d;
  logic [4:0]      memwb_rd_addr_q,    memwb_rd_addr_d;
  logic [XLEN-1:0] memwb_alu_result_q, memwb_alu_result_d;
  logic [XLEN-1:0] memwb_read_data_q,  memwb_read_data_d;
  logic [XLEN-1:0] memwb_mem_addr_q,   memwb_mem_addr_d;
  logic [3:0]      memwb_mem_rmask_q,  memwb_mem_rmask_d;
  logic [3:0]      memwb_mem_wmask_q,  memwb_mem_wmask_d;
  logic [XLEN-1:0] memwb_mem_wdata_q,  memwb_mem_wdata_d;

  logic            is_load;
  logic            is_store;
  logic            memop;
  logic            req_active;
  logic            advance;
  logic [1:0]      off;
  logic [3:0]      lane_mask;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_data;

  // ---- MEM stage: request generation and alignment ----
  // Load wins when both load and store are (illegally) asserted.
  assign is_load    = exmem_valid & exmem_mem_read;
  assign is_store   = exmem_valid & exmem_mem_write & ~exmem_mem_read;
  assign memop      = exmem_valid & (exmem_mem_read | exmem_mem_write);
  assign off        = exmem_alu_result[1:0];
  assign lane_mask  = access_mask(exmem_funct3[1:0], off);
  assign load_data  = load_align(exmem_funct3, off, dmem.dmem_rdata);
  assign store_data = store_shift(exmem_funct3[1:0], exmem_rs2_data);

  // rst_n gates the request so it drops the instant reset asserts, not at
  // the next clock edge.
  assign req_active = rst_n & memop & (state_q != ST_DONE);

  assign dmem.dmem_read        = req_active & is_load;
  assign dmem.dmem_write       = req_active & is_store;
  assign dmem.dmem_addr        = {exmem_alu_result[XLEN-1:2], 2'b00};
  assign dmem.dmem_wdata       = store_data;
  assign dmem.dmem_byte_enable = dmem.dmem_write ? lane_mask : 4'b0000;

  // A same-cycle response clears the stall, so zero-wait accesses cost nothing.
  assign dside_stall_n = ~(req_active & ~dmem.dmem_resp);
  assign advance       = dside_stall_n & istall_n;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        // Responses without a live memop (e.g. stale after reset) are dropped.
        if (memop) begin
          if (!dmem.dmem_resp) begin
            state_d = ST_REQ;
          end else if (!istall_n) begin
            state_d = ST_DONE;
            hold_d  = load_data;
          end
        end
      end
      ST_REQ: begin
        if (dmem.dmem_resp) begin
          if (istall_n) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            hold_d  = load_data;
          end
        end
      end
      ST_DONE: begin
        if (istall_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- MEM/WB register ----
  always_comb begin
    memwb_valid_d      = memwb_valid_q;
    memwb_reg_write_d  = memwb_reg_write_q;
    memwb_is_load_d    = memwb_is_load_q;
    memwb_rd_addr_d    = memwb_rd_addr_q;
    memwb_alu_result_d = memwb_alu_result_q;
    memwb_read_data_d  = memwb_read_data_q;
    memwb_mem_addr_d   = memwb_mem_addr_q;
    memwb_mem_rmask_d  = memwb_mem_rmask_q;
    memwb_mem_wmask_d  = memwb_mem_wmask_q;
    memwb_mem_wdata_d  = memwb_mem_wdata_q;
    if (advance) begin
      memwb_valid_d      = exmem_valid;
      memwb_reg_write_d  = exmem_valid & exmem_reg_write;
      memwb_is_load_d    = is_load;
      memwb_rd_addr_d    = exmem_rd_addr;
      memwb_alu_result_d = exmem_alu_result;
      // In DONE the cache has already moved on; the parked word is the answer.
      memwb_read_data_d  = (state_q == ST_DONE) ? hold_q : load_data;
      memwb_mem_addr_d   = exmem_alu_result;
      memwb_mem_rmask_d  = is_load  ? lane_mask : 4'b0000;
      memwb_mem_wmask_d  = is_store ? lane_mask : 4'b0000;
      memwb_mem_wdata_d  = store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      hold_q             <= '0;
      memwb_valid_q      <= 1'b0;
      memwb_reg_write_q  <= 1'b0;
      memwb_is_load_q    <= 1'b0;
      memwb_rd_addr_q    <= '0;
      memwb_alu_result_q <= '0;
      memwb_read_data_q  <= '0;
      memwb_mem_addr_q   <= '0;
      memwb_mem_rmask_q  <= '0;
      memwb_mem_wmask_q  <= '0;
      memwb_mem_wdata_q  <= '0;
    end else begin
      state_q            <= state_d;
      hold_q             <= hold_d;
      memwb_valid_q      <= memwb_valid_d;
      memwb_reg_write_q  <= memwb_reg_write_d;
      memwb_is_load_q    <= memwb_is_load_d;
      memwb_rd_addr_q    <= memwb_rd_addr_d;
      memwb_alu_result_q <= memwb_alu_result_d;
      memwb_read_data_q  <= memwb_read_data_d;
      memwb_mem_addr_q   <= memwb_mem_addr_d;
      memwb_mem_rmask_q  <= memwb_mem_rmask_d;
      memwb_mem_wmask_q  <= memwb_mem_wmask_d;
      memwb_mem_wdata_q  <= memwb_mem_wdata_d;
    end
  end

  assign memwb_valid      = memwb_valid_q;
  assign memwb_reg_write  = memwb_reg_write_q;
  assign memwb_is_load    = memwb_is_load_q;
  assign memwb_rd_addr    = memwb_rd_addr_q;
  assign memwb_alu_result = memwb_alu_result_q;
  assign memwb_read_data  = memwb_read_data_q;
  assign memwb_mem_addr   = memwb_mem_addr_q;
  assign memwb_mem_rmask  = memwb_mem_rmask_q;
  assign memwb_mem_wmask  = memwb_mem_wmask_q;
  assign memwb_mem_wdata  = memwb_mem_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
// Directed bench for mem_access. Expected MEM/WB contents are pushed onto a
// scoreboard queue when each instruction is driven and popped/compared after
// the clock edge on which the stage advances; during stalls the register is
// compared against the last popped entry.
// -----------------------------------------------------------------------------
module tb_mem_access;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        is_load;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exmem_valid;
  logic [31:0] exmem_alu_result;
  logic [31:0] exmem_rs2_data;
  logic [2:0]  exmem_funct3;
  logic        exmem_mem_read;
  logic        exmem_mem_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd_addr;
  logic        istall_n;
  logic        dside_stall_n;
  logic        memwb_valid;
  logic        memwb_reg_write;
  logic        memwb_is_load;
  logic [4:0]  memwb_rd_addr;
  logic [31:0] memwb_alu_result;
  logic [31:0] memwb_read_data;
  logic [31:0] memwb_mem_addr;
  logic [3:0]  memwb_mem_rmask;
  logic [3:0]  memwb_mem_wmask;
  logic [31:0] memwb_mem_wdata;

  mem_access_if bus ();

  mem_access dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .exmem_valid      (exmem_valid),
    .exmem_alu_result (exmem_alu_result),
    .exmem_rs2_data   (exmem_rs2_data),
    .exmem_funct3     (exmem_funct3),
    .exmem_mem_read   (exmem_mem_read),
    .exmem_mem_write  (exmem_mem_write),
    .exmem_reg_write  (exmem_reg_write),
    .exmem_rd_addr    (exmem_rd_addr),
    .istall_n         (istall_n),
    .dmem             (bus),
    .dside_stall_n    (dside_stall_n),
    .memwb_valid      (memwb_valid),
    .memwb_reg_write  (memwb_reg_write),
    .memwb_is_load    (memwb_is_load),
    .memwb_rd_addr    (memwb_rd_addr),
    .memwb_alu_result (memwb_alu_result),
    .memwb_read_data  (memwb_read_data),
    .memwb_mem_addr   (memwb_mem_addr),
    .memwb_mem_rmask  (memwb_mem_rmask),
    .memwb_mem_wmask  (memwb_mem_wmask),
    .memwb_mem_wdata  (memwb_mem_wdata)
  );

  always #5 clk = ~clk;

  int  checks   = 0;
  int  failures = 0;
  wb_t exp_q[$];
  wb_t last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag, input wb_t e);
    chk({tag, ".valid"},     32'(memwb_valid),      32'(e.valid));
    chk({tag, ".reg_write"}, 32'(memwb_reg_write),  32'(e.reg_write));
    chk({tag, ".is_load"},   32'(memwb_is_load),    32'(e.is_load));
    chk({tag, ".rd"},        32'(memwb_rd_addr),    32'(e.rd));
    chk({tag, ".alu"},       memwb_alu_result,      e.alu);
    chk({tag, ".rdata"},     memwb_read_data,       e.rdata);
    chk({tag, ".addr"},      memwb_mem_addr,        e.addr);
    chk({tag, ".rmask"},     32'(memwb_mem_rmask),  32'(e.rmask));
    chk({tag, ".wmask"},     32'(memwb_mem_wmask),  32'(e.wmask));
    chk({tag, ".wdata"},     memwb_mem_wdata,       e.wdata);
  endtask

  task automatic push(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                      input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] addr,
                      input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd);
    wb_t e;
    e.valid = v; e.reg_write = rw; e.is_load = ld; e.rd = rd; e.alu = alu;
    e.rdata = rdata; e.addr = addr; e.rmask = rm; e.wmask = wm; e.wdata = wd;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      last = exp_q.pop_front();
      check_wb(tag, last);
    end
  endtask

  task automatic check_hold(input string tag);
    check_wb(tag, last);
  endtask

  task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [2:0] f3, input logic rd_m, input logic wr_m,
                        input logic regw, input logic [4:0] rd);
    exmem_valid = v; exmem_alu_result = alu; exmem_rs2_data = rs2; exmem_funct3 = f3;
    exmem_mem_read = rd_m; exmem_mem_write = wr_m; exmem_reg_write = regw; exmem_rd_addr = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    last = '0;
    rst_n = 1'b0;
    istall_n = 1'b1;
    bus.dmem_rdata = 32'h0;
    bus.dmem_resp = 1'b0;
    set_ex(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);

    // Reset state
    #2;
    check_hold("reset");
    chk("reset.dmem_read", 32'(bus.dmem_read), 32'd0);
    chk("reset.stall_n", 32'(dside_stall_n), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LB 0x1003, zero-wait response
    set_ex(1'b1, 32'h1003, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd3);
    bus.dmem_rdata = 32'h80FF_1234;
    bus.dmem_resp = 1'b1;
    #1;
    chk("lb.dmem_read", 32'(bus.dmem_read), 32'd1);
    chk("lb.dmem_addr", bus.dmem_addr, 32'h1000);
    chk("lb.stall_n", 32'(dside_stall_n), 32'd1);
    push(1, 1, 1, 5'd3, 32'h1003, 32'hFFFF_FF80, 32'h1003, 4'b1000, 4'b0000, 32'h0);
    tick();
    pop_check("lb");

    // SB 0x2002
    set_ex(1'b1, 32'h2002, 32'h0000_00AB, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0);
    bus.dmem_rdata = 32'h0;
    bus.dmem_resp = 1'b1;
    #1;
    chk("sb.dmem_write", 32'(bus.dmem_write), 32'd1);
    chk("sb.dmem_read", 32'(bus.dmem_read), 32'd0);
    chk("sb.dmem_wdata", bus.dmem_wdata, 32'hABAB_ABAB);
    chk("sb.byte_enable", 32'(bus.dmem_byte_enable), 32'h4);
    chk("sb.dmem_addr", bus.dmem_addr, 32'h2000);
    push(1, 0, 0, 5'd0, 32'h2002, 32'h0, 32'h2002, 4'b0000, 4'b0100, 32'hABAB_ABAB);
    tick();
    pop_check("sb");

    // LHU 0x3002, response after 3 stall cycles
    set_ex(1'b1, 32'h3002, 32'h0, 3'b101, 1'b1, 1'b0, 1'b1, 5'd7);
    bus.dmem_resp = 1'b0;
    bus.dmem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lhu.stall_n", 32'(dside_stall_n), 32'd0);
      chk("lhu.dmem_read", 32'(bus.dmem_read), 32'd1);
      tick();
      check_hold("lhu.hold");
    end
    bus.dmem_resp = 1'b1;
    bus.dmem_rdata = 32'hBEEF_0001;
    #1;
    chk("lhu.resp_stall_n", 32'(dside_stall_n), 32'd1);
    push(1, 1, 1, 5'd7, 32'h3002, 32'h0000_BEEF, 32'h3002, 4'b1100, 4'b0000, 32'h0);
    tick();
    pop_check("lhu");

    // LW 0x4000, response while front end stalled for 2 cycles
    set_ex(1'b1, 32'h4000, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd9);
    bus.dmem_rdata = 32'h1234_5678;
    bus.dmem_resp = 1'b1;
    istall_n = 1'b0;
    #1;
    chk("lw.zero_wait_stall_n", 32'(dside_stall_n), 32'd1);
    tick();
    check_hold("lw.istall1");
    bus.dmem_resp = 1'b0;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw.done_dmem_read", 32'(bus.dmem_read), 32'd0);
    chk("lw.done_stall_n", 32'(dside_stall_n), 32'd1);
    tick();
    check_hold("lw.istall2");
    istall_n = 1'b1;
    #1;
    chk("lw.release_dmem_read", 32'(bus.dmem_read), 32'd0);
    push(1, 1, 1, 5'd9, 32'h4000, 32'h1234_5678, 32'h4000, 4'b1111, 4'b0000, 32'h0);
    tick();
    pop_check("lw");

    // Bubble with stray control bits, then an ALU op
    set_ex(1'b0, 32'h10, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd1);
    bus.dmem_rdata = 32'h0;
    bus.dmem_resp = 1'b0;
    #1;
    chk("bubble.dmem_read", 32'(bus.dmem_read), 32'd0);
    chk("bubble.stall_n", 32'(dside_stall_n), 32'd1);
    push(0, 0, 0, 5'd1, 32'h10, 32'h0, 32'h10, 4'b0000, 4'b0000, 32'h0);
    tick();
    pop_check("bubble");

    set_ex(1'b1, 32'h42, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5);
    #1;
    chk("alu.dmem_read", 32'(bus.dmem_read), 32'd0);
    chk("alu.dmem_write", 32'(bus.dmem_write), 32'd0);
    push(1, 1, 0, 5'd5, 32'h42, 32'h0, 32'h42, 4'b0000, 4'b0000, 32'h0);
    tick();
    pop_check("alu");

    // Reset while a load is outstanding
    set_ex(1'b1, 32'h5000, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd10);
    #1;
    chk("rst.pre_dmem_read", 32'(bus.dmem_read), 32'd1);
    tick();
    check_hold("rst.req_hold");
    chk("rst.req_stall_n", 32'(dside_stall_n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst.async_dmem_read", 32'(bus.dmem_read), 32'd0);
    last = '0;
    check_hold("rst.cleared");
    #2;
    rst_n = 1'b1;
    set_ex(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);
    bus.dmem_resp = 1'b1;
    bus.dmem_rdata = 32'h7777_7777;
    istall_n = 1'b0;
    tick();
    check_hold("stale");
    bus.dmem_resp = 1'b0;
    istall_n = 1'b1;
    set_ex(1'b1, 32'h6000, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd11);
    #1;
    chk("stale.next_dmem_read", 32'(bus.dmem_read), 32'd1);
    chk("stale.next_stall_n", 32'(dside_stall_n), 32'd0);
    bus.dmem_resp = 1'b1;
    bus.dmem_rdata = 32'hCAFE_F00D;
    push(1, 1, 1, 5'd11, 32'h6000, 32'hCAFE_F00D, 32'h6000, 4'b1111, 4'b0000, 32'h0);
    tick();
    pop_check("post_rst_lw");

    set_ex(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);
    bus.dmem_resp = 1'b0;
    tick();
    chk("scoreboard.drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage plus MEM/WB pipeline register; sits directly upstream of write-back.
- Takes the EX/MEM fields and drives the data-cache request/response handshake.
- Aligns and sign-extends load data, shifts store data and byte enables, and generates `dside_stall_n`.
- Holds a returned load response until the front end releases its stall, so cache data is never lost.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- exmem_valid  in  1  EX/MEM holds a real instruction (0 = bubble)
- exmem_alu_result  in  32  effective address for loads/stores, result otherwise
- exmem_rs2_data  in  32  store source data
- exmem_funct3  in  3  load/store width and sign (RV32I encoding)
- exmem_mem_read  in  1  instruction is a load
- exmem_mem_write  in  1  instruction is a store
- exmem_reg_write  in  1  instruction writes rd
- exmem_rd_addr  in  5  destination register
- istall_n  in  1  instruction-side not stalled
- dmem_rdata  in  32  cache read data, word-aligned
- dmem_resp  in  1  cache response; one cycle per request
- dmem_read  out  1  load request
- dmem_write  out  1  store request
- dmem_addr  out  32  request address, bits [1:0] forced to 0
- dmem_wdata  out  32  shifted store data
- dmem_byte_enable  out  4  store byte enables
- dside_stall_n  out  1  data-side not stalled
- memwb_valid  out  1  MEM/WB holds a real instruction
- memwb_reg_write  out  1  MEM/WB writes rd
- memwb_is_load  out  1  MEM/WB instruction is a load
- memwb_rd_addr  out  5  destination register
- memwb_alu_result  out  32  forwarded ALU result
- memwb_read_data  out  32  aligned, extended load data
- memwb_mem_addr  out  32  unaligned effective address (monitor)
- memwb_mem_rmask  out  4  load byte mask (monitor)
- memwb_mem_wmask  out  4  store byte mask (monitor)
- memwb_mem_wdata  out  32  shifted store data (monitor)

Behaviour:
- memop = exmem_valid & (exmem_mem_read | exmem_mem_write).
- State machine: states IDLE, REQ, DONE.
  - Reset: state IDLE; all memwb_* outputs 0; hold register 0.
- Request outputs (combinational, active when memop & state != DONE):
  - `dmem_read` = load; `dmem_write` = store.
  - Outside that condition both requests are 0.
  - Requests stay asserted, stable, until `dmem_resp`.
- IDLE:
  - memop & !dmem_resp -> REQ.
  - dmem_resp & !istall_n -> DONE.
  - Otherwise stay IDLE.
- REQ:
  - dmem_resp & istall_n -> IDLE.
  - dmem_resp & !istall_n -> DONE; capture aligned load data in the hold register.
- DONE:
  - No request outstanding.
  - istall_n -> IDLE.
- Stall: `dside_stall_n` = !(memop & state != DONE & !dmem_resp). A zero-wait response gives no stall cycle.
- Advance = dside_stall_n & istall_n.
- On advance, MEM/WB loads:
  - valid = exmem_valid.
  - reg_write = exmem_valid & exmem_reg_write.
  - is_load = exmem_valid & exmem_mem_read.
  - read_data = hold register if state == DONE, else aligned dmem_rdata.
  - Remaining fields are copied.
- Without advance, MEM/WB holds its contents.
- A bubble (exmem_valid = 0) loads valid, reg_write, is_load, rmask and wmask as 0.
- Load alignment, with off = addr[1:0]:
  - LB/LBU: byte `off`, sign- or zero-extended.
  - LH/LHU: half selected by addr[1]; addr[0] ignored.
  - LW: addr[1:0] ignored.
  - rmask = 0001<<off, 0011<<(2*addr[1]), or 1111 respectively.
- Store alignment:
  - SB: byte replicated x4, byte_enable = 0001<<off.
  - SH: half replicated x2, byte_enable = 0011<<(2*addr[1]).
  - SW: byte_enable = 1111.
  - wmask = byte_enable.
- Reset mid-operation:
  - Requests drop immediately (asynchronous reset).
  - A dmem_resp arriving while state == IDLE with no memop is ignored.
- Load and store both asserted is illegal input; load takes priority.

Test Plan:
- LB at addr 0x1003, dmem_rdata 0x80FF_1234, resp same cycle, istall_n = 1 -> no stall; next cycle memwb_read_data = 0xFFFF_FF80, rmask = 1000, is_load = 1.
- SB at 0x2002, rs2 = 0x0000_00AB -> dmem_wdata 0xABAB_ABAB, byte_enable 0100, dmem_addr 0x2000; memwb_mem_wmask 0100.
- LHU at 0x3002, resp after 3 cycles -> dside_stall_n low exactly 3 cycles; memwb_read_data = upper half zero-extended; MEM/WB unchanged during the stall.
- Load response while istall_n = 0 for 2 cycles -> state DONE, dmem_read deasserted, dside_stall_n = 1; on istall_n rise memwb_read_data equals the captured value; dmem_rdata changes meanwhile are ignored.
- Bubble then non-memory ALU op (rd = 5, result 0x42) -> memwb_valid 0 then 1, reg_write 1, alu_result 0x42, no dmem requests.
- rst_n low during REQ -> dmem_read 0 asynchronously, all memwb_* 0; stale dmem_resp after release produces no MEM/WB update.
